fetch_stage2_predecode: RTL and testbench
=========================================

Name: fetch_stage2_predecode

Overview:
Fetch stage 2. Registers the 4-instruction bundle and per-slot BTB/predictor results from fetch stage 1, and predecodes each slot for control type and direct target. Detects BTB misses and wrong direct targets, then issues the ID-level redirect (flagRecoverID/targetAddrID) and the call/return RAS fix-ups back to fetch stage 1. Emits a valid-masked bundle to decode.

Parameters:
SIZE_PC, 32, PC width in bits.
INST_W, 64, instruction width; slot i PC = pc + 8*i.
SLOTS, 4, instructions per bundle; the logic is fixed at 4.

Ports:
clk  in  1  clock
reset  in  1  reset
stall_i  in  1  hold stage register; suppress redirect
flush_i  in  1  squash stage contents (EX recovery/exception)
fs1Ready_i  in  1  fetch stage 1 bundle valid (no I$ miss)
instBundle_i  in  SLOTS*INST_W  bundle, slot 0 in LSBs
pc_i  in  SIZE_PC  slot 0 PC
addrRAS_CP_i  in  SIZE_PC  RAS checkpoint top
btbHit_i  in  SLOTS  per-slot BTB hit
btbTarget_i  in  SLOTS*SIZE_PC  per-slot BTB/RAS target
prediction_i  in  SLOTS  per-slot direction prediction
flagRecoverID_o  out  1  redirect fetch stage 1
targetAddrID_o  out  SIZE_PC  redirect target
flagCallID_o  out  1  push callPCID_o (BTB-missed call)
callPCID_o  out  SIZE_PC  return address of the call
flagRtrID_o  out  1  BTB-missed return; fetch stage 1 uses RAS_CP
fs2Ready_o  out  1  bundle valid to decode
instBundle_o  out  SLOTS*INST_W  registered bundle
pc_o  out  SIZE_PC  registered PC
validMask_o  out  SLOTS  per-slot valid after squash
predTaken_o  out  SLOTS  per-slot final taken prediction
recoverCount_o  out  32  saturating count of ID redirects

Behaviour:
- Reset is asynchronous and active-high. While reset is high: all stage registers, outputs and recoverCount_o = 0, and valid = 0.
- Stage register: on each posedge with ~stall_i, capture all inputs. Set valid <= fs1Ready_i & ~flush_i & ~flagRecoverID_o. The bundle fetched on the wrong path in the redirect cycle is therefore dropped.
- flush_i has top priority: valid <= 0 even when stall_i is high. Registered data is don't-care.
- Under stall_i with no flush, all registers hold.
- Predecode per slot, using opcode [63:56]. Opcode classes come from package constants: COND, JUMP_DIR, CALL_DIR, JUMP_IND, CALL_IND, RETURN, OTHER.
  - COND target = slotPC + 8 + (sext(imm[15:0]) << 3).
  - JUMP_DIR/CALL_DIR target = {slotPC[31:29], imm[25:0], 3'b000}.
  - Indirect targets are unknown here.
- Per-slot taken:
  - COND: prediction_i & btbHit_i.
  - JUMP_DIR, CALL_DIR, RETURN: 1.
  - Indirect: btbHit_i.
  - OTHER: 0.
- The first taken slot k (lowest index) sets validMask_o[j] = 0 for j > k. All other slots follow valid.
- Redirect is required at k when any of the following holds:
  - (a) Direct type and (~btbHit_i[k] or btbTarget_i[k] != decoded target).
  - (b) RETURN and ~btbHit_i[k].
  - (c) A non-control slot k' carries btbHit_i[k'] as the first hit. Treat it as not-taken, and redirect to slotPC(k') + 8 unless a taken slot precedes it.
- flagRecoverID_o = valid & ~stall_i & required. It is combinational from the stage register and is a one-cycle pulse per bundle by construction.
- targetAddrID_o = decoded target, or the fall-through per (c).
- flagRtrID_o = flagRecoverID_o & RETURN.
- flagCallID_o = flagRecoverID_o & CALL_DIR & ~btbHit_i[k]. callPCID_o = slotPC(k) + 8.
- Indirect targets are never redirected here; execute resolves them.
- predTaken_o: bit k = 1 only for the taken slot.
- fs2Ready_o = valid. Latency from fetch stage 1 to decode is 1 cycle.
- recoverCount_o increments on each flagRecoverID_o and saturates at 0xFFFFFFFF.
- Simultaneous flush_i and required redirect: flush wins. No redirect is issued, because valid is cleared next edge. The current-cycle pulse is gated by ~flush_i.

Decomposition:
- Package fetch_pkg holds:
  - opcode class constants;
  - ctrl type encoding 00 return / 01 call / 10 jump / 11 cond;
  - SLOTS, INST_W, INST_BYTES = 8.
- Sub-module predecode_slot, instantiated 4x. Inputs: instruction and slotPC. Outputs: class, isCtrl, directTarget.

Test Plan:
- Reset mid-run with valid bundle, then release → all outputs 0 and recoverCount_o = 0; fs2Ready_o rises 1 cycle after the first fs1Ready_i.
- pc_i = 0x1000, slot 1 COND imm = 4, btbHit = 0, pred = 0 → no redirect; validMask = 1111.
- pc_i = 0x1000, slot 1 JUMP_DIR imm26 = 0x200, btbHit_i = 0 → flagRecoverID_o = 1, targetAddrID_o = 0x1000, validMask = 0011, next captured bundle invalid.
- Slot 0 CALL_DIR with BTB miss → flagCallID_o = 1, callPCID_o = pc + 8; slot 2 RETURN with BTB miss and no prior taken slot → flagRtrID_o = 1.
- Redirect condition present with stall_i = 1 for 3 cycles → no pulse during stall, exactly one pulse on release, recoverCount_o += 1.
- flush_i while stall_i = 1 → valid = 0 next edge, no redirect; recoverCount_o is 0xFFFFFFFF and holds after a further redirect.

Source files
------------

// File: rtl/fetch_pkg.sv
// Fetch stage 2 shared definitions: bundle geometry,
// opcode classes and control-type encoding.
package fetch_pkg;

   localparam int SLOTS      = 4;
   localparam int INST_W     = 64;
   localparam int INST_BYTES = 8;
   localparam int IDX_W      = 2;

   localparam logic [7:0] OP_COND     = 8'h01;
   localparam logic [7:0] OP_JUMP_DIR = 8'h02;
   localparam logic [7:0] OP_CALL_DIR = 8'h03;
   localparam logic [7:0] OP_JUMP_IND = 8'h04;
   localparam logic [7:0] OP_CALL_IND = 8'h05;
   localparam logic [7:0] OP_RETURN   = 8'h06;

   typedef enum logic [2:0] {
      CLS_OTHER,
      CLS_COND,
      CLS_JUMP_DIR,
      CLS_CALL_DIR,
      CLS_JUMP_IND,
      CLS_CALL_IND,
      CLS_RETURN
   } opClass_e;

   typedef enum logic [1:0] {
      CT_RETURN = 2'b00,
      CT_CALL   = 2'b01,
      CT_JUMP   = 2'b10,
      CT_COND   = 2'b11
   } ctrlType_e;

   function automatic ctrlType_e ctrlTypeOf(opClass_e c);
      ctrlType_e t;
      case (c)
         CLS_RETURN:                 t = CT_RETURN;
         CLS_CALL_DIR, CLS_CALL_IND: t = CT_CALL;
         CLS_COND:                   t = CT_COND;
         default:                    t = CT_JUMP;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/fetch_stage2_predecode_slot.sv
// Single-slot predecode: opcode class and the
// statically known target of direct branches.
module predecode_slot
   import fetch_pkg::*;
#(
   parameter int SIZE_PC = 32
) (
   input  logic [INST_W-1:0]  inst,
   input  logic [SIZE_PC-1:0] slotPc,
   output opClass_e           opClass,
   output logic               isCtrl,
   output logic [SIZE_PC-1:0] directTarget
);

   logic [7:0]         opcode;
   logic [SIZE_PC-1:0] condOffset;
   logic [SIZE_PC-1:0] jumpTarget;
   logic               unusedInst;

   assign opcode     = inst[INST_W-1 -: 8];
   assign unusedInst = ^inst[55:26];

   // Offsets count instructions, hence the 3-bit shift.
   assign condOffset = {{(SIZE_PC-19){inst[15]}},
                        inst[15:0], 3'b000};
   assign jumpTarget = {slotPc[SIZE_PC-1:29],
                        inst[25:0], 3'b000};

   always_comb begin
      opClass = CLS_OTHER;
      unique case (1'b1)
         opcode == OP_COND:     opClass = CLS_COND;
         opcode == OP_JUMP_DIR: opClass = CLS_JUMP_DIR;
         opcode == OP_CALL_DIR: opClass = CLS_CALL_DIR;
         opcode == OP_JUMP_IND: opClass = CLS_JUMP_IND;
         opcode == OP_CALL_IND: opClass = CLS_CALL_IND;
         opcode == OP_RETURN:   opClass = CLS_RETURN;
         default:               opClass = CLS_OTHER;
      endcase
   end

   assign isCtrl = opClass != CLS_OTHER;

   always_comb begin
      directTarget = '0;
      unique case (opClass)
         CLS_COND:
            directTarget = slotPc
                         + SIZE_PC'(INST_BYTES)
                         + condOffset;
         CLS_JUMP_DIR, CLS_CALL_DIR:
            directTarget = jumpTarget;
         default:
            directTarget = '0;
      endcase
   end

endmodule

// File: rtl/fetch_stage2_predecode.sv
// Fetch stage 2: registers the fetch-1 bundle, predecodes it
// and issues ID-level redirects and RAS fix-ups.
module fetch_stage2_predecode
   import fetch_pkg::*;
#(
   parameter int SIZE_PC = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall_i,
   input  logic                      flush_i,
   input  logic                      fs1Ready_i,
   input  logic [SLOTS*INST_W-1:0]   instBundle_i,
   input  logic [SIZE_PC-1:0]        pc_i,
   input  logic [SIZE_PC-1:0]        addrRAS_CP_i,
   input  logic [SLOTS-1:0]          btbHit_i,
   input  logic [SLOTS*SIZE_PC-1:0]  btbTarget_i,
   input  logic [SLOTS-1:0]          prediction_i,
   output logic                      flagRecoverID_o,
   output logic [SIZE_PC-1:0]        targetAddrID_o,
   output logic                      flagCallID_o,
   output logic [SIZE_PC-1:0]        callPCID_o,
   output logic                      flagRtrID_o,
   output logic                      fs2Ready_o,
   output logic [SLOTS*INST_W-1:0]   instBundle_o,
   output logic [SIZE_PC-1:0]        pc_o,
   output logic [SLOTS-1:0]          validMask_o,
   output logic [SLOTS-1:0]          predTaken_o,
   output logic [31:0]               recoverCount_o
);

   logic                     validR;
   logic [SLOTS*INST_W-1:0]  instR;
   logic [SIZE_PC-1:0]       pcR;
   logic [SIZE_PC-1:0]       rasR;
   logic [SLOTS-1:0]         hitR;
   logic [SLOTS*SIZE_PC-1:0] tgtR;
   logic [SLOTS-1:0]         predR;
   logic [31:0]              recoverCnt;

   logic [SIZE_PC-1:0] slotPc [SLOTS];
   logic [SIZE_PC-1:0] btbTgt [SLOTS];
   logic [SIZE_PC-1:0] dirTgt [SLOTS];
   opClass_e           cls    [SLOTS];
   logic [SLOTS-1:0]   isCtrl;
   logic [SLOTS-1:0]   taken;

   logic               anyTaken;
   logic               anyHit;
   logic [IDX_W-1:0]   takenIdx;
   logic [IDX_W-1:0]   hitIdx;
   logic               isDirect;
   logic               reqDirect;
   logic               reqReturn;
   logic               reqFall;
   logic               required;
   logic               flagRecover;
   logic [SIZE_PC-1:0] redirectTarget;

   for (genvar g = 0; g < SLOTS; g++) begin : gSlot
      assign slotPc[g] = pcR + SIZE_PC'(g*INST_BYTES);
      assign btbTgt[g] = tgtR[g*SIZE_PC +: SIZE_PC];

      predecode_slot #(
         .SIZE_PC (SIZE_PC)
      ) uPredecode (
         .inst         (instR[g*INST_W +: INST_W]),
         .slotPc       (slotPc[g]),
         .opClass      (cls[g]),
         .isCtrl       (isCtrl[g]),
         .directTarget (dirTgt[g])
      );
   end

   always_comb begin
      taken = '0;
      for (int i = 0; i < SLOTS; i++) begin
         unique case (cls[i])
            CLS_COND:
               taken[i] = predR[i] & hitR[i];
            CLS_JUMP_DIR, CLS_CALL_DIR, CLS_RETURN:
               taken[i] = 1'b1;
            CLS_JUMP_IND, CLS_CALL_IND:
               taken[i] = hitR[i];
            default:
               taken[i] = 1'b0;
         endcase
      end
   end

   // Walk high to low so the lowest index wins.
   always_comb begin
      anyTaken = 1'b0;
      takenIdx = '0;
      anyHit   = 1'b0;
      hitIdx   = '0;
      for (int i = SLOTS-1; i >= 0; i--) begin
         if (taken[i]) begin
            anyTaken = 1'b1;
            takenIdx = IDX_W'(i);
         end
         if (hitR[i]) begin
            anyHit = 1'b1;
            hitIdx = IDX_W'(i);
         end
      end
   end

   assign isDirect  = cls[takenIdx] inside
                      {CLS_COND, CLS_JUMP_DIR, CLS_CALL_DIR};
   assign reqDirect = anyTaken & isDirect
                    & (~hitR[takenIdx]
                    | (btbTgt[takenIdx] != dirTgt[takenIdx]));
   assign reqReturn = anyTaken & ~hitR[takenIdx]
                    & (cls[takenIdx] == CLS_RETURN);
   // A BTB hit on a non-branch redirected fetch-1 wrongly.
   assign reqFall   = anyHit & ~isCtrl[hitIdx]
                    & ~(anyTaken & (takenIdx < hitIdx));
   assign required  = reqDirect | reqReturn | reqFall;

   always_comb begin
      redirectTarget = dirTgt[takenIdx];
      if (reqFall)
         redirectTarget = slotPc[hitIdx]
                        + SIZE_PC'(INST_BYTES);
      else if (reqReturn)
         redirectTarget = rasR;
   end

   assign flagRecover = validR & ~stall_i
                      & ~flush_i & required;

   assign flagRecoverID_o = flagRecover;
   assign targetAddrID_o  = required ? redirectTarget : '0;
   assign flagRtrID_o     = flagRecover & ~reqFall & reqReturn;
   assign flagCallID_o    = flagRecover & ~reqFall
                          & ~hitR[takenIdx]
                          & (cls[takenIdx] == CLS_CALL_DIR);
   assign callPCID_o      = flagCallID_o
                          ? slotPc[takenIdx] + SIZE_PC'(INST_BYTES)
                          : '0;

   always_comb begin
      validMask_o = {SLOTS{validR}};
      predTaken_o = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (anyTaken && IDX_W'(i) > takenIdx)
            validMask_o[i] = 1'b0;
         predTaken_o[i] = validR & anyTaken
                        & (takenIdx == IDX_W'(i));
      end
   end

   assign fs2Ready_o     = validR;
   assign instBundle_o   = instR;
   assign pc_o           = pcR;
   assign recoverCount_o = recoverCnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         validR     <= 1'b0;
         instR      <= '0;
         pcR        <= '0;
         rasR       <= '0;
         hitR       <= '0;
         tgtR       <= '0;
         predR      <= '0;
         recoverCnt <= '0;
      end else begin
         if (flush_i) begin
            validR <= 1'b0;
         end else if (~stall_i) begin
            validR <= fs1Ready_i & ~flagRecover;
            instR  <= instBundle_i;
            pcR    <= pc_i;
            rasR   <= addrRAS_CP_i;
            hitR   <= btbHit_i;
            tgtR   <= btbTarget_i;
            predR  <= prediction_i;
         end
         if (flagRecover && recoverCnt != 32'hFFFF_FFFF)
            recoverCnt <= recoverCnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_stage2_predecode.sv
// Directed and randomized checks of fetch stage 2 against
// a slot-walking reference model of the redirect rules.
module tb_fetch_stage2_predecode;
   import fetch_pkg::*;

   typedef logic [255:0] w_t;

   localparam int K_OTHER = 0;
   localparam int K_COND  = 1;
   localparam int K_JDIR  = 2;
   localparam int K_CDIR  = 3;
   localparam int K_JIND  = 4;
   localparam int K_CIND  = 5;
   localparam int K_RET   = 6;

   logic         clk = 1'b0;
   logic         reset;
   logic         stall_i;
   logic         flush_i;
   logic         fs1Ready_i;
   logic [255:0] instBundle_i;
   logic [31:0]  pc_i;
   logic [31:0]  addrRAS_CP_i;
   logic [3:0]   btbHit_i;
   logic [127:0] btbTarget_i;
   logic [3:0]   prediction_i;
   logic         flagRecoverID_o;
   logic [31:0]  targetAddrID_o;
   logic         flagCallID_o;
   logic [31:0]  callPCID_o;
   logic         flagRtrID_o;
   logic         fs2Ready_o;
   logic [255:0] instBundle_o;
   logic [31:0]  pc_o;
   logic [3:0]   validMask_o;
   logic [3:0]   predTaken_o;
   logic [31:0]  recoverCount_o;

   fetch_stage2_predecode #(.SIZE_PC(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .fs1Ready_i      (fs1Ready_i),
      .instBundle_i    (instBundle_i),
      .pc_i            (pc_i),
      .addrRAS_CP_i    (addrRAS_CP_i),
      .btbHit_i        (btbHit_i),
      .btbTarget_i     (btbTarget_i),
      .prediction_i    (prediction_i),
      .flagRecoverID_o (flagRecoverID_o),
      .targetAddrID_o  (targetAddrID_o),
      .flagCallID_o    (flagCallID_o),
      .callPCID_o      (callPCID_o),
      .flagRtrID_o     (flagRtrID_o),
      .fs2Ready_o      (fs2Ready_o),
      .instBundle_o    (instBundle_o),
      .pc_o            (pc_o),
      .validMask_o     (validMask_o),
      .predTaken_o     (predTaken_o),
      .recoverCount_o  (recoverCount_o)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nPass   = 0;

   task automatic check(input string tag,
                        input w_t obs, input w_t exp);
      nChecks++;
      if (obs === exp) nPass++;
      else $display("FAIL %s: got %0h want %0h",
                    tag, obs, exp);
   endtask

   // Reference model state: what stage 2 should be holding.
   logic         mValid;
   logic [255:0] mInst;
   logic [31:0]  mPc, mRas, mCount;
   logic [3:0]   mHit, mPred;
   logic [127:0] mTgt;

   logic        eFlag, eCall, eRtr;
   logic [31:0] eTarget, eCallPc;
   logic [3:0]  eMask, ePred;

   function automatic int kindOf(logic [7:0] op);
      case (op)
         OP_COND:     return K_COND;
         OP_JUMP_DIR: return K_JDIR;
         OP_CALL_DIR: return K_CDIR;
         OP_JUMP_IND: return K_JIND;
         OP_CALL_IND: return K_CIND;
         OP_RETURN:   return K_RET;
         default:     return K_OTHER;
      endcase
   endfunction

   function automatic logic [31:0] dirTarget(
      logic [63:0] inst, logic [31:0] spc);
      int kd;
      int off;
      kd  = kindOf(inst[63:56]);
      off = $signed(inst[15:0]);
      if (kd == K_COND)
         return spc + 32'd8 + 32'(off * 8);
      if (kd == K_JDIR || kd == K_CDIR)
         return (spc & 32'hE000_0000)
              | ({6'd0, inst[25:0]} << 3);
      return 32'd0;
   endfunction

   task automatic zeroModel();
      mValid = 0; mInst = '0; mPc = '0; mRas = '0;
      mCount = '0; mHit = '0; mPred = '0; mTgt = '0;
   endtask

   task automatic evalModel();
      int k, h, kd;
      logic tk, req, callReq, rtrReq;
      logic [31:0] spc, dt;
      k = -1; h = -1;
      req = 0; callReq = 0; rtrReq = 0;
      eTarget = '0; eCallPc = '0;
      for (int i = 0; i < 4; i++) begin
         kd = kindOf(mInst[i*64+56 +: 8]);
         case (kd)
            K_COND:               tk = mHit[i] & mPred[i];
            K_JDIR, K_CDIR, K_RET: tk = 1'b1;
            K_JIND, K_CIND:       tk = mHit[i];
            default:              tk = 1'b0;
         endcase
         if (tk && k < 0) k = i;
         if (mHit[i] && h < 0) h = i;
      end
      if (h >= 0 && kindOf(mInst[h*64+56 +: 8]) == K_OTHER
          && !(k >= 0 && k < h)) begin
         req = 1;
         eTarget = mPc + 32'(8*h + 8);
      end else if (k >= 0) begin
         kd  = kindOf(mInst[k*64+56 +: 8]);
         spc = mPc + 32'(8*k);
         dt  = dirTarget(mInst[k*64 +: 64], spc);
         if ((kd == K_COND || kd == K_JDIR || kd == K_CDIR)
             && (!mHit[k] || mTgt[k*32 +: 32] != dt)) begin
            req = 1;
            eTarget = dt;
            callReq = (kd == K_CDIR) && !mHit[k];
            eCallPc = spc + 32'd8;
         end else if (kd == K_RET && !mHit[k]) begin
            req = 1;
            eTarget = mRas;
            rtrReq = 1;
         end
      end
      eFlag = mValid & !stall_i & !flush_i & req;
      eCall = eFlag & callReq;
      eRtr  = eFlag & rtrReq;
      eMask = mValid ? 4'hF : 4'h0;
      ePred = 4'h0;
      if (mValid && k >= 0) begin
         ePred[k] = 1'b1;
         for (int j = k + 1; j < 4; j++) eMask[j] = 1'b0;
      end
   endtask

   task automatic checkAll();
      evalModel();
      check("ready", w_t'(fs2Ready_o), w_t'(mValid));
      check("recover", w_t'(flagRecoverID_o), w_t'(eFlag));
      if (eFlag)
         check("target", w_t'(targetAddrID_o), w_t'(eTarget));
      check("call", w_t'(flagCallID_o), w_t'(eCall));
      if (eCall)
         check("callPc", w_t'(callPCID_o), w_t'(eCallPc));
      check("rtr", w_t'(flagRtrID_o), w_t'(eRtr));
      check("mask", w_t'(validMask_o), w_t'(eMask));
      check("predTaken", w_t'(predTaken_o), w_t'(ePred));
      check("count", w_t'(recoverCount_o), w_t'(mCount));
      if (mValid) begin
         check("pc", w_t'(pc_o), w_t'(mPc));
         check("inst", instBundle_o, mInst);
      end
   endtask

   task automatic updateModel();
      if (reset) begin
         zeroModel();
      end else begin
         if (eFlag && mCount != 32'hFFFF_FFFF) mCount++;
         if (flush_i) begin
            mValid = 0;
         end else if (!stall_i) begin
            mValid = fs1Ready_i & !eFlag;
            mInst  = instBundle_i;
            mPc    = pc_i;
            mRas   = addrRAS_CP_i;
            mHit   = btbHit_i;
            mTgt   = btbTarget_i;
            mPred  = prediction_i;
         end
      end
   endtask

   task automatic tick();
      #1 checkAll();
      @(posedge clk);
      updateModel();
      @(negedge clk);
      #1;
   endtask

   task automatic clearIn();
      fs1Ready_i = 1; stall_i = 0; flush_i = 0;
      instBundle_i = '0; btbHit_i = '0; prediction_i = '0;
      btbTarget_i = '0; pc_i = 32'h1000;
      addrRAS_CP_i = 32'h4444_0000;
   endtask

   task automatic setSlot(input int s, input logic [7:0] op,
                          input logic [31:0] imm);
      instBundle_i[s*64 +: 64] = {op, 24'h0, imm};
   endtask

   task automatic loadJump();
      clearIn();
      setSlot(1, OP_JUMP_DIR, 32'h200);
   endtask

   task automatic randomCycle();
      logic [7:0] ops [8];
      logic [31:0] spc;
      ops = '{8'h00, OP_COND, OP_JUMP_DIR, OP_CALL_DIR,
              OP_JUMP_IND, OP_CALL_IND, OP_RETURN, 8'hA5};
      stall_i      = ($urandom_range(0, 7) == 0);
      flush_i      = ($urandom_range(0, 15) == 0);
      fs1Ready_i   = ($urandom_range(0, 4) != 0);
      pc_i         = $urandom & 32'hFFFF_FFF8;
      addrRAS_CP_i = $urandom & 32'hFFFF_FFF8;
      prediction_i = 4'($urandom);
      for (int s = 0; s < 4; s++) begin
         instBundle_i[s*64 +: 64] =
            {ops[$urandom_range(0, 7)], 24'($urandom), $urandom};
         btbHit_i[s] = ($urandom_range(0, 3) == 0);
         spc = pc_i + 32'(8*s);
         btbTarget_i[s*32 +: 32] = $urandom_range(0, 1) != 0
            ? dirTarget(instBundle_i[s*64 +: 64], spc)
            : $urandom;
      end
   endtask

   logic [31:0] cnt0;

   initial begin
      reset = 1;
      clearIn();
      fs1Ready_i = 0;
      zeroModel();
      @(negedge clk);
      #1;
      tick();
      tick();
      reset = 0;

      // Not-taken conditional: no redirect, full mask.
      clearIn();
      setSlot(1, OP_COND, 32'h4);
      tick();
      check("condReady", w_t'(fs2Ready_o), w_t'(1'b1));
      check("condNoRedir", w_t'(flagRecoverID_o), w_t'(1'b0));
      check("condMask", w_t'(validMask_o), w_t'(4'hF));

      // Direct jump missing in the BTB.
      loadJump();
      tick();
      check("jdirFlag", w_t'(flagRecoverID_o), w_t'(1'b1));
      check("jdirTgt", w_t'(targetAddrID_o), w_t'(32'h1000));
      check("jdirMask", w_t'(validMask_o), w_t'(4'b0011));
      clearIn();
      tick();
      check("jdirDrop", w_t'(fs2Ready_o), w_t'(1'b0));

      // Missed call on slot 0.
      clearIn();
      setSlot(0, OP_CALL_DIR, 32'h10);
      tick();
      check("callFlag", w_t'(flagCallID_o), w_t'(1'b1));
      check("callPc", w_t'(callPCID_o), w_t'(32'h1008));
      clearIn();
      tick();

      // Missed return on slot 2.
      clearIn();
      setSlot(2, OP_RETURN, 32'h0);
      tick();
      check("rtrFlag", w_t'(flagRtrID_o), w_t'(1'b1));
      check("rtrTgt", w_t'(targetAddrID_o), w_t'(32'h4444_0000));
      clearIn();
      tick();

      // Redirect held off by stall.
      loadJump();
      tick();
      cnt0 = mCount;
      stall_i = 1;
      fs1Ready_i = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stallNoPulse", w_t'(flagRecoverID_o), w_t'(1'b0));
      end
      stall_i = 0;
      #1 check("stallRelease", w_t'(flagRecoverID_o), w_t'(1'b1));
      tick();
      check("stallCount", w_t'(recoverCount_o), w_t'(cnt0 + 1));
      tick();

      // Flush during stall beats a pending redirect.
      loadJump();
      tick();
      stall_i = 1;
      flush_i = 1;
      #1 check("flushNoPulse", w_t'(flagRecoverID_o), w_t'(1'b0));
      tick();
      check("flushValid", w_t'(fs2Ready_o), w_t'(1'b0));

      // Counter saturation.
      force dut.recoverCnt = 32'hFFFF_FFFE;
      #1;
      release dut.recoverCnt;
      mCount = 32'hFFFF_FFFE;
      for (int r = 0; r < 2; r++) begin
         loadJump();
         tick();
         tick();
         check("satCount", w_t'(recoverCount_o),
               w_t'(32'hFFFF_FFFF));
      end

      // Reset in the middle of a valid bundle.
      clearIn();
      tick();
      reset = 1;
      zeroModel();
      #1;
      check("rstReady", w_t'(fs2Ready_o), w_t'(1'b0));
      check("rstCount", w_t'(recoverCount_o), w_t'(32'd0));
      check("rstPc", w_t'(pc_o), w_t'(32'd0));
      tick();
      reset = 0;
      clearIn();
      #1 check("latency0", w_t'(fs2Ready_o), w_t'(1'b0));
      tick();
      check("latency1", w_t'(fs2Ready_o), w_t'(1'b1));

      for (int c = 0; c < 600; c++) begin
         randomCycle();
         tick();
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
